// File: rtl/chunk_adder.sv
// chunk_adder
//   Multi-cycle adder/subtractor. WIDTH-bit operands are added CHUNK bits per
//   clock, LSB chunk first, with the carry held in a register between chunks.
//   Latency from accept to result is WIDTH/CHUNK cycles.
//
//   Handshake rule (both sides): a transfer happens on a rising edge of i_clk
//   where valid and ready are both 1. o_ready is high only in IDLE and o_valid
//   only in DONE. Both are registered and never depend on i_valid or i_ready
//   in the same cycle.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     synchronous active-low reset
//   i_valid     operand request valid
//   o_ready     block can accept operands (IDLE)
//   i_a, i_b    operands, WIDTH bits
//   i_c         carry-in for addition (ignored when i_sub=1)
//   i_sub       0: A+B+i_c, 1: A-B
//   o_valid     result valid (DONE)
//   i_ready     consumer accepts the result
//   o_sum       result modulo 2^WIDTH
//   o_carry     carry out of the MSB (for subtraction, 1 = no borrow)
//   o_overflow  signed overflow
//   o_state     debug view of the FSM state
module chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow,
    output logic [1:0]       o_state
);

    localparam int STEPS  = WIDTH / CHUNK;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic               carry_q, carry_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;

    // One CHUNK-wide ripple slice. The operand registers shift right each
    // step, so the active chunk is always the low CHUNK bits.
    logic [CHUNK-1:0]   s_chunk;
    logic [CHUNK:0]     c_chain;
    logic [WIDTH-1:0]   work_next;

    always_comb begin
        c_chain    = '0;
        s_chunk    = '0;
        c_chain[0] = carry_q;
        for (int i = 0; i < CHUNK; i++) begin
            s_chunk[i]   = a_q[i] ^ b_q[i] ^ c_chain[i];
            c_chain[i+1] = (a_q[i] & b_q[i]) | (c_chain[i] & (a_q[i] ^ b_q[i]));
        end
        // Chunk sums enter at the top and move down, so after STEPS steps
        // chunk 0 sits at the bottom.
        work_next = (work_q >> CHUNK) | (WIDTH'(s_chunk) << (WIDTH - CHUNK));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        carry_d = carry_q;
        step_d  = step_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        ready_d = ready_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_a;
                    // Subtraction is A + ~B + 1.
                    b_d     = i_sub ? ~i_b : i_b;
                    carry_d = i_sub ? 1'b1 : i_c;
                    step_d  = '0;
                    work_d  = '0;
                    ready_d = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                work_d  = work_next;
                carry_d = c_chain[CHUNK];
                step_d  = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    sum_d   = work_next;
                    cout_d  = c_chain[CHUNK];
                    // Carry into the MSB is the last internal carry of the
                    // final chunk.
                    ovf_d   = c_chain[CHUNK] ^ c_chain[CHUNK-1];
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            step_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            step_q  <= step_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_sum      = sum_q;
    assign o_carry    = cout_q;
    assign o_overflow = ovf_q;
    assign o_state    = state_q;

endmodule
